// File: rtl/buf_rd_arbiter_pkg.sv
// Shared constants, state encoding and sizing helper for the PU input-buffer
// read arbiter and its tag FIFO.
package buf_rd_arbiter_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int REQ_VECGEN     = 0;
  localparam int REQ_WEIGHT     = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  // A single requester still needs a one-bit tag.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/buf_rd_tag_fifo.sv
// Tag FIFO remembering which requester issued each outstanding buffer read,
// in issue order, so returned beats can be routed back.
module buf_rd_tag_fifo
  import buf_rd_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 1,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [TAG_W-1:0] push_tag_i,
  input  logic             pop_i,
  output logic [TAG_W-1:0] pop_tag_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic             do_push_s;
  logic             do_pop_s;

  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (count_o == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign do_push_s = push_i && (!full_o || pop_i);
  assign do_pop_s  = pop_i && !empty_o;
  assign pop_tag_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_tag_i;
    end
  end

endmodule

// File: rtl/buf_rd_arbiter.sv
// Round-robin burst arbiter sharing the PU input-buffer read port; tags each
// issued read and steers the returned beat to the requester that issued it.
module buf_rd_arbiter
  import buf_rd_arbiter_pkg::*;
#(
  parameter int  NUM_REQ    = 2,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  BURST_LEN  = 8,
  parameter int  MAX_OUT    = 4,
  localparam int TAG_W      = tag_width(NUM_REQ),
  localparam int OUT_W      = $clog2(MAX_OUT) + 1,
  localparam int CNT_W      = $clog2(BURST_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    rd_ready,
  input  logic                  buffer_read_empty,
  output logic                  buffer_read_req,
  input  logic                  buffer_read_data_valid,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_W-1:0]      owner,
  output logic                  busy,
  output logic                  err_unexpected
);

  arb_state_e                state_q, state_d;
  logic [TAG_W-1:0]          owner_q, owner_d;
  logic [TAG_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]          beat_cnt_q, beat_cnt_d;
  logic [TAG_W-1:0]          hi_pick_s, lo_pick_s, pick_s;
  logic                      hi_any_s;
  logic                      issue_s, pop_s;
  logic                      fifo_full_s, fifo_empty_s;
  logic [TAG_W-1:0]          pop_tag_s;
  logic [OUT_W-1:0]          outstanding_s;
  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic [DATA_WIDTH-1:0]     rsp_data_q;
  logic                      err_q;

  // Reset gates the strobe so nothing issues while the tag FIFO is clearing.
  assign issue_s = !reset && (state_q == BURST) && req[owner_q]
                   && !buffer_read_empty && !fifo_full_s;
  assign pop_s   = buffer_read_data_valid && !fifo_empty_s;

  buf_rd_tag_fifo #(
    .DEPTH (MAX_OUT),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (issue_s),
    .push_tag_i (owner_q),
    .pop_i      (pop_s),
    .pop_tag_o  (pop_tag_s),
    .full_o     (fifo_full_s),
    .empty_o    (fifo_empty_s),
    .count_o    (outstanding_s)
  );

  // First requesting index at or after rr_ptr, else the lowest one (wrap).
  always_comb begin
    hi_pick_s = '0;
    lo_pick_s = '0;
    hi_any_s  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_pick_s = TAG_W'(i);
        if (TAG_W'(i) >= rr_ptr_q) begin
          hi_pick_s = TAG_W'(i);
          hi_any_s  = 1'b1;
        end else begin
          hi_any_s  = hi_any_s;
        end
      end else begin
        lo_pick_s = lo_pick_s;
      end
    end
    pick_s = hi_any_s ? hi_pick_s : lo_pick_s;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d    = pick_s;
          beat_cnt_d = '0;
          state_d    = BURST;
        end else begin
          state_d    = IDLE;
        end
      end
      BURST: begin
        if (issue_s) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end else begin
          beat_cnt_d = beat_cnt_q;
        end
        // Stalls on empty/full keep the grant; only a full burst or a dropped req releases it.
        if ((issue_s && (beat_cnt_q == CNT_W'(BURST_LEN - 1))) || !req[owner_q]) begin
          state_d  = IDLE;
          rr_ptr_d = (owner_q == TAG_W'(NUM_REQ - 1)) ? '0 : owner_q + TAG_W'(1);
        end else begin
          state_d  = BURST;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Beats with no outstanding tag are flagged and never routed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      rsp_valid_q <= pop_s ? (NUM_REQ'(1) << pop_tag_s) : '0;
      if (pop_s) begin
        rsp_data_q <= read_data;
      end
      if (buffer_read_data_valid && fifo_empty_s) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_ready          = '0;
    rd_ready[owner_q] = issue_s;
  end

  assign buffer_read_req = issue_s;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign owner           = owner_q;
  assign busy            = (state_q != IDLE) || (outstanding_s != '0);
  assign err_unexpected  = err_q;

endmodule
